// File: rtl/gray_count_rx_pkg.sv
// Shared types and helpers for the gray-count receiver.
// Optional feature macro used by gray_count_rx: GRAY_COUNT_RX_ERRCNT_EN.
package gray_count_rx_pkg;

    localparam int unsigned ERRCNT_W   = 8;
    localparam int unsigned GRAY_MAX_W = 32;

    typedef enum logic {
        FLUSH,
        RUN
    } rx_state_t;

    // Gray-to-binary for a code of width w, zero-extended to GRAY_MAX_W.
    // Bit i of the binary value is the XOR of every gray bit at or above i.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(
        input logic [GRAY_MAX_W-1:0] g,
        input int unsigned           w
    );
        logic [GRAY_MAX_W-1:0] b;
        b = '0;
        for (int unsigned i = 0; i < GRAY_MAX_W; i++) begin
            if (i < w) begin
                b[i] = ^(g >> i);
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_count_rx_sync.sv
// Multi-flop synchronizer chain bringing the asynchronous gray count into clk.
module gray_sync_chain #(
    parameter int unsigned W           = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage [SYNC_STAGES];

    // Shift the sampled gray code down the chain; all stages clear on reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/gray_count_rx.sv
// Gray-count receiver: synchronizes a gray edge count, decodes it, turns
// each +1 step into an event, keeps a saturating total and flags illegal jumps.
// Optional error counter output enabled by GRAY_COUNT_RX_ERRCNT_EN.
module gray_count_rx
    import gray_count_rx_pkg::*;
#(
    parameter int unsigned W           = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ACC_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     gray_in,
    input  logic             total_clr,
    input  logic             err_clr,
    output logic [W-1:0]     bin_out,
    output logic             event_valid,
    output logic [W-1:0]     event_delta,
    output logic [ACC_W-1:0] total,
    output logic             total_sat,
    output logic             err_pulse,
    output logic             err_flag
`ifdef GRAY_COUNT_RX_ERRCNT_EN
    ,
    output logic [ERRCNT_W-1:0] err_count
`endif
);

    rx_state_t        state;
    rx_state_t        state_next;
    logic [2:0]       flush_cnt;
    logic [2:0]       flush_cnt_next;
    logic [W-1:0]     gray_sync;
    logic [W-1:0]     bin_dec;
    logic [W-1:0]     bin_prev;
    logic [W-1:0]     step;
    logic             step_evt;
    logic             step_err;
    logic [ACC_W-1:0] total_base;
    logic [ACC_W-1:0] total_next;

    gray_sync_chain #(
        .W           (W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (gray_in),
        .q   (gray_sync)
    );

    assign bin_dec = W'(gray2bin(GRAY_MAX_W'(gray_sync), W));

    // FSM state and flush counter registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= FLUSH;
            flush_cnt <= '0;
        end else begin
            state     <= state_next;
            flush_cnt <= flush_cnt_next;
        end
    end

    // Flush covers the chain plus decode register so stale reset zeros are
    // never compared against the first real sample; RUN classifies steps.
    always_comb begin
        state_next     = state;
        flush_cnt_next = flush_cnt;
        step_evt       = 1'b0;
        step_err       = 1'b0;
        step           = bin_out - bin_prev;
        case (state)
            FLUSH: begin
                if (flush_cnt == 3'(SYNC_STAGES)) begin
                    state_next = RUN;
                end else begin
                    flush_cnt_next = flush_cnt + 3'd1;
                end
            end
            RUN: begin
                step_evt = (step == W'(1));
                step_err = (step != '0) && (step != W'(1));
            end
            default: begin
                state_next = FLUSH;
            end
        endcase
    end

    // Saturating total: clear first, then add the current event.
    always_comb begin
        total_base = total_clr ? '0 : total;
        total_next = total_base;
        if (step_evt && (total_base != '1)) begin
            total_next = total_base + ACC_W'(1);
        end
    end

    // Decode register, previous-value tracking and event/error outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bin_out     <= '0;
            bin_prev    <= '0;
            event_valid <= 1'b0;
            event_delta <= '0;
            err_pulse   <= 1'b0;
            err_flag    <= 1'b0;
            total       <= '0;
        end else begin
            bin_out     <= bin_dec;
            // During flush bin_prev tracks the value about to land in bin_out,
            // so the first RUN comparison sees zero difference.
            bin_prev    <= (state == FLUSH) ? bin_dec : bin_out;
            event_valid <= step_evt;
            event_delta <= step_evt ? step : '0;
            err_pulse   <= step_err;
            err_flag    <= step_err | (err_flag & ~err_clr);
            total       <= total_next;
        end
    end

    assign total_sat = (total == '1);

`ifdef GRAY_COUNT_RX_ERRCNT_EN
    // Saturating count of illegal transitions; a same-cycle error survives clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_count <= '0;
        end else if (err_clr) begin
            err_count <= step_err ? ERRCNT_W'(1) : '0;
        end else if (step_err && (err_count != '1)) begin
            err_count <= err_count + ERRCNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_gray_count_rx.sv
// Self-checking bench for gray_count_rx: directed scenarios plus randomized
// stimulus checked against a behavioural model. Two instances share stimulus:
// one with a 16-bit total and one with a 3-bit total for saturation.
module tb_gray_count_rx;

    localparam int unsigned S = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  gray_in = '0;
    logic        total_clr = 1'b0;
    logic        err_clr = 1'b0;

    logic [3:0]  bin_out, event_delta;
    logic        event_valid, total_sat, err_pulse, err_flag;
    logic [15:0] total;

    logic [3:0]  s_bin_out, s_event_delta;
    logic        s_event_valid, s_total_sat, s_err_pulse, s_err_flag;
    logic [2:0]  s_total;

`ifdef GRAY_COUNT_RX_ERRCNT_EN
    logic [7:0]  err_count, s_err_count;
`endif

    int n_pass = 0;
    int n_total = 0;

    gray_count_rx #(.W(4), .SYNC_STAGES(S), .ACC_W(16)) dut (
        .clk (clk), .rst (rst), .gray_in (gray_in),
        .total_clr (total_clr), .err_clr (err_clr),
        .bin_out (bin_out), .event_valid (event_valid), .event_delta (event_delta),
        .total (total), .total_sat (total_sat),
        .err_pulse (err_pulse), .err_flag (err_flag)
`ifdef GRAY_COUNT_RX_ERRCNT_EN
        , .err_count (err_count)
`endif
    );

    gray_count_rx #(.W(4), .SYNC_STAGES(S), .ACC_W(3)) dut_sat (
        .clk (clk), .rst (rst), .gray_in (gray_in),
        .total_clr (total_clr), .err_clr (err_clr),
        .bin_out (s_bin_out), .event_valid (s_event_valid), .event_delta (s_event_delta),
        .total (s_total), .total_sat (s_total_sat),
        .err_pulse (s_err_pulse), .err_flag (s_err_flag)
`ifdef GRAY_COUNT_RX_ERRCNT_EN
        , .err_count (s_err_count)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // bin_out shows gray_in from SYNC_STAGES+1 edges back; the queue holds the
    // values still in transit. Events are judged on the shown value one edge later.
    logic [3:0] q_gray [$];
    logic [3:0] m_bin, m_prev;
    logic       m_ev, m_err, m_flag;
    int         m_flush, m_tot, m_tot3, m_ecnt;

    function automatic logic [3:0] g2b(input logic [3:0] g);
        return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
    endfunction

    function automatic logic [3:0] b2g(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic model_edge();
        logic [3:0] old_bin;
        logic [3:0] d;
        if (!rst) begin
            q_gray.delete();
            repeat (S) q_gray.push_back(4'd0);
            m_bin = 0; m_prev = 0; m_ev = 0; m_err = 0; m_flag = 0;
            m_flush = S + 1; m_tot = 0; m_tot3 = 0; m_ecnt = 0;
        end else begin
            old_bin = m_bin;
            m_bin = g2b(q_gray[S-1]);
            q_gray.push_front(gray_in);
            void'(q_gray.pop_back());
            if (m_flush > 0) begin
                m_ev = 0; m_err = 0; m_prev = m_bin; m_flush--;
            end else begin
                d = old_bin - m_prev;
                m_ev = (d == 4'd1);
                m_err = (d > 4'd1);
                m_prev = old_bin;
            end
            if (total_clr) begin m_tot = 0; m_tot3 = 0; end
            if (m_ev) begin
                if (m_tot < 65535) m_tot++;
                if (m_tot3 < 7) m_tot3++;
            end
            m_flag = m_err | (m_flag & !err_clr);
            if (err_clr) m_ecnt = m_err ? 1 : 0;
            else if (m_err && m_ecnt < 255) m_ecnt++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 0; gray_in = 4'b0000; total_clr = 0; err_clr = 0;
        tick(); tick();
        n_total++;
        if ({bin_out, event_valid, event_delta, total, err_pulse, err_flag} !== '0)
            $display("FAIL reset_state: got bin=%0d ev=%b dl=%0d tot=%0d ep=%b ef=%b, want all 0",
                     bin_out, event_valid, event_delta, total, err_pulse, err_flag);
        else n_pass++;
        rst = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_total++;
            if ({bin_out, event_valid, err_pulse, total} !== '0)
                $display("FAIL reset_idle cyc%0d: got bin=%0d ev=%b ep=%b tot=%0d, want 0 0 0 0",
                         i, bin_out, event_valid, err_pulse, total);
            else n_pass++;
        end
    endtask

    task automatic test_single_step();
        gray_in = 4'b0001;
        tick(); tick();
        n_total++;
        if (bin_out !== 4'd0) $display("FAIL step_bin_k2: got %0d want 0", bin_out);
        else n_pass++;
        tick();
        n_total++;
        if (bin_out !== 4'd1 || event_valid !== 1'b0)
            $display("FAIL step_k3: got bin=%0d ev=%b want bin=1 ev=0", bin_out, event_valid);
        else n_pass++;
        tick();
        n_total++;
        if (event_valid !== 1'b1 || event_delta !== 4'd1 || total !== 16'd1)
            $display("FAIL step_k4: got ev=%b dl=%0d tot=%0d want 1 1 1", event_valid, event_delta, total);
        else n_pass++;
        tick();
        n_total++;
        if (event_valid !== 1'b0) $display("FAIL step_k5: got ev=%b want 0", event_valid);
        else n_pass++;
    endtask

    task automatic test_full_walk();
        int n_ev = 0;
        logic [3:0] last_bin = 4'hf;
        logic [3:0] last_dl = 4'h0;
        for (int b = 2; b <= 16; b++) begin
            gray_in = b2g(4'(b));
            repeat ($urandom_range(1, 3)) begin
                tick();
                if (event_valid) begin n_ev++; last_bin = bin_out; last_dl = event_delta; end
            end
        end
        repeat (6) begin
            tick();
            if (event_valid) begin n_ev++; last_bin = bin_out; last_dl = event_delta; end
        end
        n_total++;
        if (n_ev != 15 || total !== 16'd16)
            $display("FAIL walk_count: got events=%0d tot=%0d want 15 16", n_ev, total);
        else n_pass++;
        n_total++;
        if (last_bin !== 4'd0 || last_dl !== 4'd1 || err_flag !== 1'b0)
            $display("FAIL walk_wrap: got bin=%0d dl=%0d ef=%b want 0 1 0", last_bin, last_dl, err_flag);
        else n_pass++;
    endtask

    task automatic test_illegal();
        gray_in = 4'b0011;
        repeat (4) tick();
        n_total++;
        if (err_pulse !== 1'b1 || err_flag !== 1'b1 || event_valid !== 1'b0 || total !== 16'd16)
            $display("FAIL err_jump: got ep=%b ef=%b ev=%b tot=%0d want 1 1 0 16",
                     err_pulse, err_flag, event_valid, total);
        else n_pass++;
        tick();
        n_total++;
        if (err_pulse !== 1'b0 || err_flag !== 1'b1)
            $display("FAIL err_sticky: got ep=%b ef=%b want 0 1", err_pulse, err_flag);
        else n_pass++;
        err_clr = 1; tick(); err_clr = 0;
        n_total++;
        if (err_flag !== 1'b0) $display("FAIL err_clear: got ef=%b want 0", err_flag);
        else n_pass++;
        gray_in = b2g(4'd7);
        repeat (3) tick();
        err_clr = 1; tick(); err_clr = 0;
        n_total++;
        if (err_pulse !== 1'b1 || err_flag !== 1'b1)
            $display("FAIL err_set_wins: got ep=%b ef=%b want 1 1", err_pulse, err_flag);
        else n_pass++;
`ifdef GRAY_COUNT_RX_ERRCNT_EN
        n_total++;
        if (err_count !== 8'd1) $display("FAIL err_count_set_wins: got %0d want 1", err_count);
        else n_pass++;
`endif
        tick();
    endtask

    task automatic test_reset_mid();
        total_clr = 1; tick(); total_clr = 0;
        for (int b = 8; b <= 12; b++) begin
            gray_in = b2g(4'(b));
            tick(); tick();
        end
        repeat (4) tick();
        n_total++;
        if (total !== 16'd5) $display("FAIL mid_pre_total: got %0d want 5", total);
        else n_pass++;
        gray_in = 4'b0110;
        rst = 0; tick(); tick(); rst = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_total++;
            if (event_valid !== 1'b0 || err_pulse !== 1'b0)
                $display("FAIL mid_flush cyc%0d: got ev=%b ep=%b want 0 0", i, event_valid, err_pulse);
            else n_pass++;
        end
        n_total++;
        if (bin_out !== 4'd4 || total !== 16'd0 || err_flag !== 1'b0)
            $display("FAIL mid_after: got bin=%0d tot=%0d ef=%b want 4 0 0", bin_out, total, err_flag);
        else n_pass++;
    endtask

    task automatic test_saturation();
        for (int b = 5; b <= 13; b++) begin
            gray_in = b2g(4'(b));
            tick(); tick();
        end
        repeat (4) tick();
        n_total++;
        if (s_total !== 3'd7 || s_total_sat !== 1'b1 || total !== 16'd9 || total_sat !== 1'b0)
            $display("FAIL sat_hold: got s_tot=%0d s_sat=%b tot=%0d sat=%b want 7 1 9 0",
                     s_total, s_total_sat, total, total_sat);
        else n_pass++;
        gray_in = b2g(4'd14);
        repeat (3) tick();
        total_clr = 1; tick(); total_clr = 0;
        n_total++;
        if (s_event_valid !== 1'b1 || s_total !== 3'd1 || s_total_sat !== 1'b0 || total !== 16'd1)
            $display("FAIL clr_with_event: got ev=%b s_tot=%0d s_sat=%b tot=%0d want 1 1 0 1",
                     s_event_valid, s_total, s_total_sat, total);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [3:0] cur = 4'd14;
        int r;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r >= 85) cur = 4'($urandom_range(0, 15));
            else if (r >= 40) cur = cur + 4'd1;
            gray_in = b2g(cur);
            total_clr = ($urandom_range(0, 29) == 0);
            err_clr = ($urandom_range(0, 9) == 0);
            tick();
            n_total++;
            if (bin_out !== m_bin || event_valid !== m_ev || event_delta !== 4'(m_ev))
                $display("FAIL rnd_event cyc%0d: got bin=%0d ev=%b dl=%0d want %0d %b %0d",
                         i, bin_out, event_valid, event_delta, m_bin, m_ev, m_ev);
            else n_pass++;
            n_total++;
            if (err_pulse !== m_err || err_flag !== m_flag)
                $display("FAIL rnd_err cyc%0d: got ep=%b ef=%b want %b %b", i, err_pulse, err_flag, m_err, m_flag);
            else n_pass++;
            n_total++;
            if (total !== 16'(m_tot) || s_total !== 3'(m_tot3) || s_total_sat !== (m_tot3 == 7))
                $display("FAIL rnd_total cyc%0d: got tot=%0d s_tot=%0d s_sat=%b want %0d %0d %b",
                         i, total, s_total, s_total_sat, m_tot, m_tot3, (m_tot3 == 7));
            else n_pass++;
            n_total++;
            if ({s_bin_out, s_event_valid, s_event_delta, s_err_pulse, s_err_flag, total_sat}
                !== {m_bin, m_ev, 4'(m_ev), m_err, m_flag, (m_tot == 65535)})
                $display("FAIL rnd_sat_inst cyc%0d: got %b want %b", i,
                         {s_bin_out, s_event_valid, s_event_delta, s_err_pulse, s_err_flag, total_sat},
                         {m_bin, m_ev, 4'(m_ev), m_err, m_flag, (m_tot == 65535)});
            else n_pass++;
`ifdef GRAY_COUNT_RX_ERRCNT_EN
            n_total++;
            if (err_count !== 8'(m_ecnt) || s_err_count !== 8'(m_ecnt))
                $display("FAIL rnd_errcnt cyc%0d: got %0d/%0d want %0d", i, err_count, s_err_count, m_ecnt);
            else n_pass++;
`endif
        end
        total_clr = 0;
        err_clr = 0;
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_full_walk();
        test_illegal();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
